lap_display_ctrl: RTL and testbench

LAP_DISPLAY_CTRL -- requirements
Module: lap_display_ctrl

---
 rtl/lap_display_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lap_display_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lap_display_ctrl.sv
// lap_display_ctrl: stopwatch display controller with hold, lap capture and
// lap recall.
//   clk, rst            : clock, synchronous active-high reset
//   counter             : live time value
//   hold_btn            : freeze/unfreeze button level (synchronised, debounced)
//   lap_btn             : lap-capture button level
//   recall_btn          : lap-recall button level
//   display             : registered value to show
//   frozen              : registered, high when display is not tracking counter
//   lap_count           : registered number of valid lap slots (0..DEPTH)
//   lap_full            : registered, high when lap_count == DEPTH
// Optional macro LAP_WRAP_EN: a lap captured with the buffer full overwrites
// the oldest slot instead of being dropped.
module lap_display_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           counter,
  input  logic                       hold_btn,
  input  logic                       lap_btn,
  input  logic                       recall_btn,
  output logic [WIDTH-1:0]           display,
  output logic                       frozen,
  output logic [$clog2(DEPTH+1)-1:0] lap_count,
  output logic                       lap_full
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    display_q, display_d;
  logic                frozen_q, frozen_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [2:0]          prev_q, prev_d;   // {lap, recall, hold}
  logic [WIDTH-1:0]    slot_q [DEPTH];
  logic                we;
  logic [IW-1:0]       waddr;
  logic [IW-1:0]       base;
  logic                hold_press, recall_press, lap_press;

`ifdef LAP_WRAP_EN
  logic [IW-1:0]       head_q, head_d;
  assign base = head_q;
`else
  assign base = '0;
`endif

  // Circular add of two slot offsets, both below DEPTH.
  function automatic logic [IW-1:0] ring_add(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (IW+1)'(DEPTH)) sum = sum - (IW+1)'(DEPTH);
    return sum[IW-1:0];
  endfunction

  // Rising-edge detection; the prev registers reset high so a held button
  // does not register a press until it is released.
  assign hold_press   = hold_btn   & ~prev_q[0];
  assign recall_press = recall_btn & ~prev_q[1];
  assign lap_press    = lap_btn    & ~prev_q[2];

  // Next-state and datapath control; one press acted on per cycle.
  always_comb begin
    state_d   = state_q;
    display_d = (state_q == LIVE) ? counter : display_q;
    count_d   = count_q;
    idx_d     = idx_q;
    prev_d    = {lap_btn, recall_btn, hold_btn};
    we        = 1'b0;
    waddr     = ring_add(base, IW'(count_q));
`ifdef LAP_WRAP_EN
    head_d    = head_q;
`endif

    if (hold_press) begin
      state_d   = (state_q == LIVE) ? HOLD : LIVE;
      display_d = counter;
      idx_d     = '0;
    end else if (recall_press) begin
      if (state_q == RECALL) begin
        if (CW'(idx_q) == count_q - CW'(1)) begin
          state_d   = LIVE;
          display_d = counter;
          idx_d     = '0;
        end else begin
          idx_d     = idx_q + IW'(1);
          display_d = slot_q[ring_add(base, idx_q + IW'(1))];
        end
      end else if (count_q != '0) begin
        state_d   = RECALL;
        idx_d     = '0;
        display_d = slot_q[base];
      end
    end else if (lap_press && state_q != RECALL) begin
      if (!full_q) begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
`ifdef LAP_WRAP_EN
        // Full buffer: replace the oldest lap and advance the ring origin.
        we     = 1'b1;
        waddr  = head_q;
        head_d = ring_add(head_q, IW'(1));
`endif
      end
    end

    full_d   = (count_d == CW'(DEPTH));
    frozen_d = (state_d != LIVE);
  end

  // Control and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LIVE;
      display_q <= '0;
      frozen_q  <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      idx_q     <= '0;
      prev_q    <= '1;
`ifdef LAP_WRAP_EN
      head_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      frozen_q  <= frozen_d;
      count_q   <= count_d;
      full_q    <= full_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
`ifdef LAP_WRAP_EN
      head_q    <= head_d;
`endif
    end
  end

  // Lap slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
    end else if (we) begin
      slot_q[waddr] <= counter;
    end
  end

  assign display   = display_q;
  assign frozen    = frozen_q;
  assign lap_count = count_q;
  assign lap_full  = full_q;

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Directed self-checking bench for lap_display_ctrl (WIDTH=32, DEPTH=4).
module tb_lap_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] counter;
  logic        hold_btn, lap_btn, recall_btn;
  logic [31:0] display;
  logic        frozen;
  logic [2:0]  lap_count;
  logic        lap_full;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic        run       = 1'b0;
  logic [31:0] last_cnt;
  logic [31:0] exp_rec [4];

  always #5 clk = ~clk;

  lap_display_ctrl #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .counter    (counter),
    .hold_btn   (hold_btn),
    .lap_btn    (lap_btn),
    .recall_btn (recall_btn),
    .display    (display),
    .frozen     (frozen),
    .lap_count  (lap_count),
    .lap_full   (lap_full)
  );

  // One clock; last_cnt is the counter value the edge sampled.
  task automatic tick();
    last_cnt = counter;
    @(posedge clk);
    #1;
    if (run) counter = counter + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Press the selected buttons for one edge, then release for one edge.
  task automatic press(input logic h, input logic r, input logic l);
    hold_btn = h; recall_btn = r; lap_btn = l;
    tick();
    hold_btn = 1'b0; recall_btn = 1'b0; lap_btn = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; counter = 32'h10;
    hold_btn = 1'b0; lap_btn = 1'b0; recall_btn = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_display", display, 32'h0);
    chk("rst_frozen", {31'd0, frozen}, 32'd0);
    chk("rst_count", {29'd0, lap_count}, 32'd0);
    chk("rst_full", {31'd0, lap_full}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_display", display, 32'h10);

    // Hold
    counter = 32'd90; run = 1'b1;
    while (counter != 32'd100) tick();
    press(1'b1, 1'b0, 1'b0);
    chk("hold_display", display, 32'd100);
    chk("hold_frozen", {31'd0, frozen}, 32'd1);
    repeat (50) tick();
    chk("hold_50_display", display, 32'd100);
    press(1'b1, 1'b0, 1'b0);
    chk("unhold_track", display, last_cnt);
    chk("unhold_frozen", {31'd0, frozen}, 32'd0);
    tick();
    chk("unhold_track2", display, last_cnt);
    run = 1'b0;

    // Lap and recall
    counter = 32'd5;  press(1'b0, 1'b0, 1'b1);
    chk("lap1_count", {29'd0, lap_count}, 32'd1);
    counter = 32'd9;  press(1'b0, 1'b0, 1'b1);
    counter = 32'd14; press(1'b0, 1'b0, 1'b1);
    chk("lap3_count", {29'd0, lap_count}, 32'd3);
    chk("lap3_full", {31'd0, lap_full}, 32'd0);
    press(1'b0, 1'b1, 1'b0);
    chk("recall0", display, 32'd5);
    chk("recall0_frozen", {31'd0, frozen}, 32'd1);
    press(1'b0, 1'b0, 1'b1);
    chk("lap_in_recall_count", {29'd0, lap_count}, 32'd3);
    chk("lap_in_recall_display", display, 32'd5);
    press(1'b0, 1'b1, 1'b0);
    chk("recall1", display, 32'd9);
    press(1'b0, 1'b1, 1'b0);
    chk("recall2", display, 32'd14);
    counter = 32'd77;
    press(1'b0, 1'b1, 1'b0);
    chk("recall_exit_display", display, 32'd77);
    chk("recall_exit_frozen", {31'd0, frozen}, 32'd0);

    // Simultaneous press: hold wins
    press(1'b1, 1'b1, 1'b1);
    chk("simul_frozen", {31'd0, frozen}, 32'd1);
    chk("simul_count", {29'd0, lap_count}, 32'd3);
    chk("simul_display", display, 32'd77);
    counter = 32'd88;
    press(1'b0, 1'b0, 1'b1);
    chk("lap_in_hold_count", {29'd0, lap_count}, 32'd4);
    chk("lap_in_hold_full", {31'd0, lap_full}, 32'd1);
    chk("lap_in_hold_display", display, 32'd77);
    press(1'b1, 1'b0, 1'b0);
    chk("hold_exit_frozen", {31'd0, frozen}, 32'd0);

    // Recall with no laps is ignored
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    counter = 32'd33;
    press(1'b0, 1'b1, 1'b0);
    chk("recall_empty_frozen", {31'd0, frozen}, 32'd0);
    chk("recall_empty_display", display, 32'd33);

    // Full buffer
    for (int i = 1; i <= 5; i++) begin
      counter = 32'(i * 10);
      press(1'b0, 1'b0, 1'b1);
      if (i == 4) chk("full4_count", {29'd0, lap_count}, 32'd4);
    end
    chk("full5_count", {29'd0, lap_count}, 32'd4);
    chk("full5_full", {31'd0, lap_full}, 32'd1);
`ifdef LAP_WRAP_EN
    exp_rec[0] = 32'd20; exp_rec[1] = 32'd30; exp_rec[2] = 32'd40; exp_rec[3] = 32'd50;
`else
    exp_rec[0] = 32'd10; exp_rec[1] = 32'd20; exp_rec[2] = 32'd30; exp_rec[3] = 32'd40;
`endif
    counter = 32'd99;
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 1'b0);
      chk($sformatf("full_recall%0d", i), display, exp_rec[i]);
    end
    chk("full_recall_frozen", {31'd0, frozen}, 32'd1);

    // Reset in RECALL with hold held through it
    hold_btn = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrec_display", display, 32'd0);
    chk("rstrec_frozen", {31'd0, frozen}, 32'd0);
    chk("rstrec_count", {29'd0, lap_count}, 32'd0);
    chk("rstrec_full", {31'd0, lap_full}, 32'd0);
    tick();
    chk("held_no_press_frozen", {31'd0, frozen}, 32'd0);
    chk("held_no_press_display", display, 32'd99);
    tick();
    chk("held_no_press_frozen2", {31'd0, frozen}, 32'd0);
    hold_btn = 1'b0;
    tick();
    press(1'b1, 1'b0, 1'b0);
    chk("repress_frozen", {31'd0, frozen}, 32'd1);
    chk("repress_display", display, 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
